// File: rtl/serial_multi_param.sv
// Bit-serial shift-add multiplier: W operand beats in (LSB first), W accumulate
// cycles, then the 2W-bit product streamed out LSB first with valid/last markers.
module serial_multi_param #(
  parameter int W      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic       a,
  input  logic       b,
  output logic       ready,
  output logic       o,
  output logic       o_valid,
  output logic       o_last,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(2 * W + 1);
  localparam int IW = $clog2(W);
  localparam logic [CW-1:0] LAST_CALC = CW'(W - 1);
  localparam logic [CW-1:0] OUT_LAST  = CW'(2 * W - 1);
  localparam logic [CW-1:0] OUT_END   = CW'(2 * W);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Handshake: an operand beat transfers on a rising edge where valid=1 and
  // ready=1; ready is high only in LOAD and beats offered otherwise are dropped.

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [W-1:0]        mcand, mplier;
  logic [2*W-1:0]      acc, acc_nxt, mcand_ext, pp;

  assign ready     = (state == LOAD);
  assign dbg_state = state;

  always_comb begin
    mcand_ext = SIGNED ? {{W{mcand[W-1]}}, mcand} : {{W{1'b0}}, mcand};
    pp        = mplier[cnt[IW-1:0]] ? (mcand_ext << cnt) : '0;
    // The multiplier sign bit carries weight -2^(W-1), so its row is subtracted.
    if (SIGNED && cnt == LAST_CALC) acc_nxt = acc - pp;
    else                            acc_nxt = acc + pp;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (valid && cnt == LAST_CALC) state_nxt = CALC;
      CALC:    if (cnt == LAST_CALC)          state_nxt = OUT;
      OUT:     if (cnt == OUT_END)            state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      o       <= 1'b0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (valid) begin
            // Shift in from the top so the first (LSB) beat lands at bit 0.
            mcand  <= {a, mcand[W-1:1]};
            mplier <= {b, mplier[W-1:1]};
            cnt    <= (cnt == LAST_CALC) ? '0 : cnt + CW'(1);
          end
        end
        CALC: begin
          acc <= acc_nxt;
          if (cnt == LAST_CALC) begin
            // Bit 0 leaves with the final partial product, so OUT starts at bit 1.
            cnt     <= CW'(1);
            o       <= acc_nxt[0];
            o_valid <= 1'b1;
            o_last  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        OUT: begin
          if (cnt == OUT_END) begin
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            o       <= 1'b0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
          end else begin
            o      <= acc[cnt];
            o_last <= (cnt == OUT_LAST);
            cnt    <= cnt + CW'(1);
          end
        end
        default: begin
          cnt     <= '0;
          o       <= 1'b0;
          o_valid <= 1'b0;
          o_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_multi_param.sv
// Bench for serial_multi_param: three configurations (W=4 unsigned, W=4 signed,
// W=8 unsigned) checked by a cycle-timeline model and a product scoreboard.
module tb_serial_multi_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] valid_v, a_v, b_v;
  logic [2:0] ready_v, o_v, ov_v, ol_v;
  logic [1:0] dbg0, dbg1, dbg2;

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {instance tag[17:16], product[15:0]}
  logic [17:0] exp_q[$];

  // Per-instance timeline model
  int          beats [3];
  int          wcnt  [3];
  logic [15:0] cap   [3];

  always #5 clk = ~clk;

  serial_multi_param #(.W(4), .SIGNED(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .valid(valid_v[0]), .a(a_v[0]), .b(b_v[0]),
    .ready(ready_v[0]), .o(o_v[0]), .o_valid(ov_v[0]), .o_last(ol_v[0]), .dbg_state(dbg0));
  serial_multi_param #(.W(4), .SIGNED(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .valid(valid_v[1]), .a(a_v[1]), .b(b_v[1]),
    .ready(ready_v[1]), .o(o_v[1]), .o_valid(ov_v[1]), .o_last(ol_v[1]), .dbg_state(dbg1));
  serial_multi_param #(.W(8), .SIGNED(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .valid(valid_v[2]), .a(a_v[2]), .b(b_v[2]),
    .ready(ready_v[2]), .o(o_v[2]), .o_valid(ov_v[2]), .o_last(ol_v[2]), .dbg_state(dbg2));

  function automatic int wv(input int idx);
    return (idx == 2) ? 8 : 4;
  endfunction

  function automatic bit sv(input int idx);
    return (idx == 1);
  endfunction

  function automatic logic [15:0] ref_prod(input int idx, input logic [15:0] av, input logic [15:0] bv);
    longint w, sa, sb, p;
    w  = wv(idx);
    sa = longint'(av) & ((64'sd1 << w) - 1);
    sb = longint'(bv) & ((64'sd1 << w) - 1);
    if (sv(idx)) begin
      if (sa >= (64'sd1 << (w - 1))) sa = sa - (64'sd1 << w);
      if (sb >= (64'sd1 << (w - 1))) sb = sb - (64'sd1 << w);
    end
    p = (sa * sb) & ((64'sd1 << (2 * w)) - 1);
    return p[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int   w, k;
      logic e_rdy, e_ov, e_ol;
      logic [15:0] mask;
      w = wv(i);
      if (!rst_n) begin
        chk($sformatf("rst_ready[%0d]", i), 32'(ready_v[i]), 32'd1);
        chk($sformatf("rst_o[%0d]", i), 32'(o_v[i]), 32'd0);
        chk($sformatf("rst_ovalid[%0d]", i), 32'(ov_v[i]), 32'd0);
        chk($sformatf("rst_olast[%0d]", i), 32'(ol_v[i]), 32'd0);
        beats[i] = 0;
        wcnt[i]  = 0;
      end else begin
        e_rdy = (wcnt[i] == 0);
        e_ov  = (wcnt[i] > w);
        k     = wcnt[i] - w - 1;
        e_ol  = e_ov && (k == 2 * w - 1);
        chk($sformatf("ready[%0d]", i), 32'(ready_v[i]), 32'(e_rdy));
        chk($sformatf("o_valid[%0d]", i), 32'(ov_v[i]), 32'(e_ov));
        chk($sformatf("o_last[%0d]", i), 32'(ol_v[i]), 32'(e_ol));
        if (!ov_v[i]) chk($sformatf("o_idle_zero[%0d]", i), 32'(o_v[i]), 32'd0);
        if (e_ov) begin
          cap[i][k] = o_v[i];
          if (k == 2 * w - 1) begin
            mask = 16'((32'd1 << (2 * w)) - 1);
            if (exp_q.size() == 0 || int'(exp_q[0][17:16]) != i) begin
              chk($sformatf("sb_expect_present[%0d]", i), 32'd0, 32'd1);
            end else begin
              chk($sformatf("product[%0d]", i), 32'(cap[i] & mask), 32'(exp_q[0][15:0]));
              void'(exp_q.pop_front());
            end
          end
        end
        if (wcnt[i] != 0) begin
          wcnt[i] = (wcnt[i] == 3 * w) ? 0 : wcnt[i] + 1;
        end else if (valid_v[i]) begin
          beats[i]++;
          if (beats[i] == w) begin
            beats[i] = 0;
            wcnt[i]  = 1;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input int idx, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] gaps);
    int w;
    w = wv(idx);
    for (int t = 0; t < 200 && !ready_v[idx]; t++) cyc();
    chk($sformatf("ready_wait[%0d]", idx), 32'(ready_v[idx]), 32'd1);
    exp_q.push_back({2'(idx), ref_prod(idx, av, bv)});
    for (int j = 0; j < w; j++) begin
      valid_v[idx] = 1'b1;
      a_v[idx]     = av[j];
      b_v[idx]     = bv[j];
      cyc();
      if (gaps[j]) begin
        valid_v[idx] = 1'b0;
        cyc();
      end
    end
    valid_v[idx] = 1'b0;
    a_v[idx]     = 1'b0;
    b_v[idx]     = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) cyc();
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (2) cyc();
  endtask

  // Called just after a rising edge; reset lands between edges.
  task automatic async_reset(input int idx);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_o", 32'(o_v[idx]), 32'd0);
    chk("arst_ovalid", 32'(ov_v[idx]), 32'd0);
    chk("arst_olast", 32'(ol_v[idx]), 32'd0);
    chk("arst_ready", 32'(ready_v[idx]), 32'd1);
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_v = '0;
    a_v     = '0;
    b_v     = '0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // W=4 unsigned: 15x15, then 5x3 with gaps after beats 0 and 2
    send_op(0, 16'hF, 16'hF, 16'h0);
    send_op(0, 16'h5, 16'h3, 16'h5);
    drain();

    // W=4 signed: -8x7 and -1x-1
    send_op(1, 16'h8, 16'h7, 16'h0);
    send_op(1, 16'hF, 16'hF, 16'h0);
    drain();

    // W=8 unsigned back-to-back: 0xFFxFF then 0x00x0x55
    send_op(2, 16'hFF, 16'hFF, 16'h0);
    send_op(2, 16'h00, 16'h55, 16'h0);
    drain();

    // Async reset mid-CALC and mid-OUT, then a fresh 3x3
    send_op(0, 16'h5, 16'h3, 16'h0);
    cyc();
    async_reset(0);
    send_op(0, 16'h7, 16'h6, 16'h0);
    repeat (6) cyc();
    async_reset(0);
    send_op(0, 16'h3, 16'h3, 16'h0);
    drain();

    // VALID held high through CALC/OUT: only the first four beats count
    exp_q.push_back({2'd0, ref_prod(0, 16'hF, 16'hF)});
    valid_v[0] = 1'b1;
    a_v[0]     = 1'b1;
    b_v[0]     = 1'b1;
    repeat (16) cyc();
    valid_v[0] = 1'b0;
    a_v[0]     = 1'b0;
    b_v[0]     = 1'b0;
    send_op(0, 16'h3, 16'h3, 16'h0);
    drain();

    // Randomised operands and gap patterns on every configuration
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 6; n++) begin
        send_op(i, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
                16'($urandom_range(0, 255)));
      end
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
